// File: rtl/mem_access_splitter.sv
// mem_access_splitter
//   Byte-addressed load/store sequencer in front of a word-wide, byte-masked
//   RAM port with one-cycle read latency. Little-endian, one request in flight.
//   Build option MISALIGNED_SPLIT_EN: when defined, accesses that cross a word
//   boundary are issued as two RAM accesses (ACC0 then ACC1) and the read data
//   is reassembled; when undefined, such accesses return rsp_err_o without
//   touching the RAM.
module mem_access_splitter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W+1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wr_mask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_FIN, S_RESP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_FIN, S_RESP} state_e;
`endif

  state_e            state_q;

  // Registered outputs
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wr_mask_q;
  logic [31:0]       mem_wdata_q;

  // Request fields captured at the handshake
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        off_q;

  // Decode of the incoming request (only consumed in IDLE)
  logic [1:0]        in_off;
  logic [ADDR_W-1:0] in_w0;
  logic [3:0]        in_smask;
  logic [2:0]        in_bytes;
  logic              in_illegal;
  logic              in_cross;
  logic              in_err;

  assign in_off   = req_addr_i[1:0];
  assign in_w0    = req_addr_i[ADDR_W+1:2];
  assign in_cross = ({1'b0, in_off} + in_bytes) > 3'd4;

  // Size decode: byte-lane mask and byte count of the access
  always_comb begin
    in_smask   = 4'b0000;
    in_bytes   = 3'd0;
    in_illegal = 1'b0;
    case (req_size_i)
      2'd0:    begin in_smask = 4'b0001; in_bytes = 3'd1; end
      2'd1:    begin in_smask = 4'b0011; in_bytes = 3'd2; end
      2'd2:    begin in_smask = 4'b1111; in_bytes = 3'd4; end
      default: in_illegal = 1'b1;
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  // Lane mask and data spread over two consecutive words
  logic [7:0]        in_m8;
  logic [63:0]       in_d64;
  logic [ADDR_W-1:0] in_w1;
  logic              cross_q;
  logic [ADDR_W-1:0] w1_q;
  logic [3:0]        mask_hi_q;
  logic [31:0]       wdata_hi_q;
  logic [31:0]       lo_q;
  logic [63:0]       rd_cat;

  assign in_m8  = {4'b0000, in_smask} << in_off;
  assign in_d64 = {32'b0, req_wdata_i} << {in_off, 3'b000};
  assign in_w1  = in_w0 + ADDR_W'(1);   // wraps at the top of the RAM
  assign in_err = in_illegal;
`else
  // Without splitting, a legal access always fits in one word
  logic [3:0]        in_m8;
  logic [31:0]       in_d64;

  assign in_m8  = in_smask << in_off;
  assign in_d64 = req_wdata_i << {in_off, 3'b000};
  assign in_err = in_illegal | in_cross;
`endif

  // Read-data alignment: pick the 32-bit window starting at the byte offset
  logic [31:0] rd_al;
  logic [31:0] rd_ext;

`ifdef MISALIGNED_SPLIT_EN
  assign rd_cat = cross_q ? {mem_rdata_i, lo_q} : {32'b0, mem_rdata_i};
  assign rd_al  = rd_cat[{1'b0, off_q, 3'b000} +: 32];
`else
  assign rd_al  = mem_rdata_i >> {off_q, 3'b000};
`endif

  // Truncate to the access size and sign- or zero-extend
  always_comb begin
    rd_ext = rd_al;
    case (size_q)
      2'd0:    rd_ext = {{24{signed_q & rd_al[7]}},  rd_al[7:0]};
      2'd1:    rd_ext = {{16{signed_q & rd_al[15]}}, rd_al[15:0]};
      default: rd_ext = rd_al;
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'b0;
      rsp_err_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_mask_q <= 4'b0000;
      mem_wdata_q   <= 32'b0;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      off_q         <= 2'd0;
`ifdef MISALIGNED_SPLIT_EN
      cross_q       <= 1'b0;
      w1_q          <= '0;
      mask_hi_q     <= 4'b0000;
      wdata_hi_q    <= 32'b0;
      lo_q          <= 32'b0;
`endif
    end else begin
      // RAM strobes last exactly one cycle unless an access state re-asserts them
      mem_en_q      <= 1'b0;
      mem_wr_mask_q <= 4'b0000;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            signed_q    <= req_signed_i;
            off_q       <= in_off;
`ifdef MISALIGNED_SPLIT_EN
            cross_q     <= in_cross;
            w1_q        <= in_w1;
            mask_hi_q   <= req_we_i ? in_m8[7:4] : 4'b0000;
            wdata_hi_q  <= in_d64[63:32];
`endif
            if (in_err) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'b0;
            end else begin
              state_q       <= S_ACC0;
              mem_en_q      <= 1'b1;
              mem_addr_q    <= in_w0;
              mem_wr_mask_q <= req_we_i ? in_m8[3:0] : 4'b0000;
              mem_wdata_q   <= in_d64[31:0];
            end
          end
        end
        S_ACC0: begin
`ifdef MISALIGNED_SPLIT_EN
          if (cross_q) begin
            state_q       <= S_ACC1;
            mem_en_q      <= 1'b1;
            mem_addr_q    <= w1_q;
            mem_wr_mask_q <= mask_hi_q;
            mem_wdata_q   <= wdata_hi_q;
          end else begin
            state_q <= S_FIN;
          end
`else
          state_q <= S_FIN;
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        S_ACC1: begin
          // First word's read data arrives now; the second arrives in FIN
          lo_q    <= mem_rdata_i;
          state_q <= S_FIN;
        end
`endif
        S_FIN: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'b0 : rd_ext;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign mem_en_o      = mem_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_mask_o = mem_wr_mask_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_splitter.sv
// tb_mem_access_splitter
//   Table of directed load/store vectors with hand-computed results, driven
//   through the sequencer against a behavioural byte-masked RAM with one-cycle
//   read latency, plus a hand-written reset-mid-access sequence.
//   Expectations follow MISALIGNED_SPLIT_EN the same way the design does.
module tb_mem_access_splitter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_sgn;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wr_mask;
  logic [31:0]   mem_wdata;
  logic [31:0]   ram_rdata;

  always #5 clk = ~clk;

  mem_access_splitter #(.ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_size_i   (req_size),
    .req_signed_i (req_sgn),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_wr_mask_o(mem_wr_mask),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (ram_rdata)
  );

  // Behavioural RAM plus a log of every enabled RAM cycle
  logic [31:0]   ram [0:1023];
  logic [AW-1:0] log_addr  [0:255];
  logic [3:0]    log_mask  [0:255];
  logic [31:0]   log_wdata [0:255];
  int            mem_total = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_wr_mask[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      ram_rdata <= ram[mem_addr];
      log_addr[mem_total[7:0]]  <= mem_addr;
      log_mask[mem_total[7:0]]  <= mem_wr_mask;
      log_wdata[mem_total[7:0]] <= mem_wdata;
      mem_total <= mem_total + 1;
    end
  end

  typedef struct {
    logic          we;
    logic [AW+1:0] addr;
    logic [1:0]    size;
    logic          sgn;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_nmem;
    logic [AW-1:0] a0;
    logic [3:0]    m0;
    logic [31:0]   d0;
    logic [AW-1:0] a1;
    logic [3:0]    m1;
    logic [31:0]   d1;
    int            hold;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(logic we, logic [AW+1:0] addr, logic [1:0] size, logic sgn,
                              logic [31:0] wdata, logic [31:0] er, logic ee, int lat, int nmem,
                              logic [AW-1:0] a0, logic [3:0] m0, logic [31:0] d0,
                              logic [AW-1:0] a1, logic [3:0] m1, logic [31:0] d1, int hold);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_nmem = nmem;
    v.a0 = a0; v.m0 = m0; v.d0 = d0; v.a1 = a1; v.m1 = m1; v.d1 = d1; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One complete request/response transaction
  task automatic do_req(input int idx, input vec_t v);
    int lat;
    int base;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_size = v.size; req_sgn = v.sgn; req_wdata = v.wdata;
    base = mem_total;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("v%0d req_ready idle", idx), 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after the handshake; the design must ignore them
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = 12'($urandom);
    req_size = 2'($urandom_range(0, 3)); req_wdata = $urandom;
    chk($sformatf("v%0d req_ready busy", idx), 32'(req_ready), 32'd0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.exp_err));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d hold%0d valid", idx, i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d hold%0d rdata", idx, i), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d hold%0d err", idx, i), 32'(rsp_err), 32'(v.exp_err));
      chk($sformatf("v%0d hold%0d req_ready", idx, i), 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid drop", idx), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d req_ready back", idx), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d mem cycles", idx), 32'(mem_total - base), 32'(v.exp_nmem));
    if (v.exp_nmem >= 1) begin
      chk($sformatf("v%0d acc0 addr", idx), 32'(log_addr[base[7:0]]), 32'(v.a0));
      chk($sformatf("v%0d acc0 mask", idx), 32'(log_mask[base[7:0]]), 32'(v.m0));
      chk($sformatf("v%0d acc0 wdata", idx), log_wdata[base[7:0]], v.d0);
    end
    if (v.exp_nmem >= 2) begin
      chk($sformatf("v%0d acc1 addr", idx), 32'(log_addr[8'(base + 1)]), 32'(v.a1));
      chk($sformatf("v%0d acc1 mask", idx), 32'(log_mask[8'(base + 1)]), 32'(v.m1));
      chk($sformatf("v%0d acc1 wdata", idx), log_wdata[8'(base + 1)], v.d1);
    end
    $display("txn %0d: we=%0b addr=%h size=%0d sgn=%0b wdata=%h -> rdata=%h err=%0b lat=%0d mem=%0d",
             idx, v.we, v.addr, v.size, v.sgn, v.wdata, v.exp_rdata, v.exp_err, lat,
             mem_total - base);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_sgn = 1'b0; req_wdata = 32'b0; rsp_ready = 1'b0;

    //            we addr     sz sg wdata         exp_rdata     err lat n  a0      m0       d0            a1      m1       d1     hold
    vecs.push_back(mk(1, 12'h010, 2, 0, 32'hDEADBEEF, 32'h00000000, 0, 3, 1, 10'h004, 4'b1111, 32'hDEADBEEF, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(1, 12'h00C, 2, 0, 32'h80011234, 32'h00000000, 0, 3, 1, 10'h003, 4'b1111, 32'h80011234, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h00E, 1, 1, 32'h00000000, 32'hFFFF8001, 0, 3, 1, 10'h003, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h00E, 1, 0, 32'h00000000, 32'h00008001, 0, 3, 1, 10'h003, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h00D, 0, 0, 32'h00000000, 32'h00000012, 0, 3, 1, 10'h003, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h00F, 0, 1, 32'h00000000, 32'hFFFFFF80, 0, 3, 1, 10'h003, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h00C, 2, 0, 32'h00000000, 32'h80011234, 0, 3, 1, 10'h003, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 5));
    vecs.push_back(mk(1, 12'h011, 1, 0, 32'h0000ABCD, 32'h00000000, 0, 3, 1, 10'h004, 4'b0110, 32'h00ABCD00, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h010, 2, 0, 32'h00000000, 32'hDEABCDEF, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(1, 12'h013, 0, 0, 32'h000000FF, 32'h00000000, 0, 3, 1, 10'h004, 4'b1000, 32'hFF000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h012, 1, 1, 32'h00000000, 32'hFFFFFFAB, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h013, 0, 1, 32'h00000000, 32'hFFFFFFFF, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h010, 3, 0, 32'h00000000, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 5));
    vecs.push_back(mk(1, 12'h010, 3, 0, 32'h12345678, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h011, 1, 0, 32'h00000000, 32'h0000ABCD, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
`ifdef MISALIGNED_SPLIT_EN
    vecs.push_back(mk(1, 12'h014, 2, 0, 32'h55667788, 32'h00000000, 0, 3, 1, 10'h005, 4'b1111, 32'h55667788, 10'h0,   4'b0000, 32'h0,        0));
    vecs.push_back(mk(1, 12'h013, 2, 0, 32'h11223344, 32'h00000000, 0, 4, 2, 10'h004, 4'b1000, 32'h44000000, 10'h005, 4'b0111, 32'h00112233, 0));
    vecs.push_back(mk(0, 12'h013, 2, 0, 32'h00000000, 32'h11223344, 0, 4, 2, 10'h004, 4'b0000, 32'h00000000, 10'h005, 4'b0000, 32'h0,        5));
    vecs.push_back(mk(0, 12'h013, 1, 1, 32'h00000000, 32'h00003344, 0, 4, 2, 10'h004, 4'b0000, 32'h00000000, 10'h005, 4'b0000, 32'h0,        0));
    vecs.push_back(mk(1, 12'hFFC, 2, 0, 32'hAABBCCDD, 32'h00000000, 0, 3, 1, 10'h3FF, 4'b1111, 32'hAABBCCDD, 10'h0,   4'b0000, 32'h0,        0));
    vecs.push_back(mk(1, 12'h000, 2, 0, 32'h00000011, 32'h00000000, 0, 3, 1, 10'h000, 4'b1111, 32'h00000011, 10'h0,   4'b0000, 32'h0,        0));
    vecs.push_back(mk(0, 12'hFFE, 2, 0, 32'h00000000, 32'h0011AABB, 0, 4, 2, 10'h3FF, 4'b0000, 32'h00000000, 10'h000, 4'b0000, 32'h0,        0));
    vecs.push_back(mk(0, 12'hFFF, 0, 0, 32'h00000000, 32'h000000AA, 0, 3, 1, 10'h3FF, 4'b0000, 32'h00000000, 10'h0,   4'b0000, 32'h0,        0));
    vecs.push_back(mk(0, 12'h010, 2, 0, 32'h00000000, 32'h44ABCDEF, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0,   4'b0000, 32'h0,        0));
    vecs.push_back(mk(1, 12'h013, 1, 0, 32'h0000BEEF, 32'h00000000, 0, 4, 2, 10'h004, 4'b1000, 32'hEF000000, 10'h005, 4'b0001, 32'h000000BE, 0));
    vecs.push_back(mk(0, 12'h014, 2, 0, 32'h00000000, 32'h551122BE, 0, 3, 1, 10'h005, 4'b0000, 32'h00000000, 10'h0,   4'b0000, 32'h0,        0));
`else
    vecs.push_back(mk(1, 12'h013, 2, 0, 32'h11223344, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h013, 2, 0, 32'h00000000, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 5));
    vecs.push_back(mk(0, 12'h013, 1, 1, 32'h00000000, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(1, 12'h013, 1, 0, 32'h0000BEEF, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'h010, 2, 0, 32'h00000000, 32'hFFABCDEF, 0, 3, 1, 10'h004, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
    vecs.push_back(mk(0, 12'hFFE, 2, 0, 32'h00000000, 32'h00000000, 1, 1, 0, 10'h000, 4'b0000, 32'h00000000, 10'h0, 4'b0000, 32'h0, 0));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wr_mask", 32'(mem_wr_mask), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req(i, vecs[i]);

    // Reset asserted in the middle of an access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sgn = 1'b0; req_wdata = 32'b0;
`ifdef MISALIGNED_SPLIT_EN
    req_addr = 12'h013;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid acc1 mem_en", 32'(mem_en), 32'd1);
    chk("mid acc1 mem_addr", 32'(mem_addr), 32'h005);
`else
    req_addr = 12'h010;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("mid acc0 mem_en", 32'(mem_en), 32'd1);
    chk("mid acc0 mem_addr", 32'(mem_addr), 32'h004);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_en", 32'(mem_en), 32'd0);
    chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid rst req_ready", 32'(req_ready), 32'd1);
    chk("mid rst mem_wr_mask", 32'(mem_wr_mask), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("txn reset: asserted mid-access and released");
    do_req(100, mk(0, 12'h00C, 2, 0, 32'h0, 32'h80011234, 0, 3, 1, 10'h003, 4'b0000, 32'h0,
                   10'h0, 4'b0000, 32'h0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
